// File: rtl/pkt_pkg.sv
// Shared definitions for the packet framer: default widths/lengths and FSM state encoding.
package pkt_pkg;

    localparam int DEF_DW    = 512;
    localparam int DEF_IDW   = 32;
    localparam int DEF_BEATS = 32;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_FTR  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-Stream register slice with registered outputs.
// Entry 0 drives the output directly; entry 1 catches a beat that arrives
// while the output is stalled. Ready depends only on occupancy, so it never
// combinationally follows out_ready.
module axis_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] out_reg, out_next;
    logic [W-1:0] spare_reg, spare_next;
    logic [1:0]   occ_reg, occ_next;
    logic         push, pop;

    assign in_ready  = resetn && (occ_reg != 2'd2);
    assign out_valid = (occ_reg != 2'd0);
    assign out_data  = out_reg;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next occupancy and entry contents; push while full cannot happen since ready is low.
    always_comb begin
        out_next   = out_reg;
        spare_next = spare_reg;
        occ_next   = occ_reg;
        if (push && !pop) begin
            if (occ_reg == 2'd0) begin
                out_next = in_data;
            end else begin
                spare_next = in_data;
            end
            occ_next = occ_reg + 2'd1;
        end else if (!push && pop) begin
            if (occ_reg == 2'd2) begin
                out_next = spare_reg;
            end
            occ_next = occ_reg - 2'd1;
        end else if (push && pop) begin
            // Only reachable with one entry held: the new beat replaces the departing one.
            out_next = in_data;
        end
    end

    // Occupancy register; reset empties the slice.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_reg <= 2'd0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    // Payload registers need no reset: they are only observed when occupancy says so.
    always_ff @(posedge clk) begin
        out_reg   <= out_next;
        spare_reg <= spare_next;
    end

endmodule

// File: rtl/pkt_framer.sv
// Strips header/footer beats from the request manager's TX stream, tags each
// payload beat with its request ID and TLAST, and counts packets and footer
// ID mismatches for the status registers.
module pkt_framer
    import pkt_pkg::*;
#(
    parameter int DW               = DEF_DW,
    parameter int IDW              = DEF_IDW,
    parameter int BEATS_PER_PACKET = DEF_BEATS
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic            AXIS_IN_TVALID,
    output logic            AXIS_IN_TREADY,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [IDW-1:0]  AXIS_OUT_TUSER,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY,
    output logic [31:0]     pkt_count,
    output logic [31:0]     err_count,
    output logic            footer_err
);

    localparam int CW = $clog2(BEATS_PER_PACKET + 1);
    localparam int SW = DW + IDW + 1;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [IDW-1:0] req_id_reg, req_id_next;
    logic [31:0]    pkt_count_reg, pkt_count_next;
    logic [31:0]    err_count_reg, err_count_next;
    logic           footer_err_reg, footer_err_next;

    logic           in_ready, in_hs, last_beat;
    logic           skid_in_valid, skid_in_ready;
    logic [SW-1:0]  skid_in_data, skid_out_data;

    // Header and footer are always consumed; only payload beats wait on the slice.
    assign in_ready       = resetn && ((state_reg != S_DATA) || skid_in_ready);
    assign in_hs          = AXIS_IN_TVALID && in_ready;
    assign last_beat      = (cnt_reg == CW'(1));
    assign skid_in_valid  = AXIS_IN_TVALID && (state_reg == S_DATA);
    assign skid_in_data   = {AXIS_IN_TDATA, req_id_reg, last_beat};

    assign AXIS_IN_TREADY = in_ready;
    assign pkt_count      = pkt_count_reg;
    assign err_count      = err_count_reg;
    assign footer_err     = footer_err_reg;
    assign {AXIS_OUT_TDATA, AXIS_OUT_TUSER, AXIS_OUT_TLAST} = skid_out_data;

    // Framing FSM: latch ID on header, count payload beats, compare ID on footer.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        req_id_next     = req_id_reg;
        pkt_count_next  = pkt_count_reg;
        err_count_next  = err_count_reg;
        footer_err_next = 1'b0;
        case (state_reg)
            S_HDR: begin
                if (in_hs) begin
                    req_id_next = AXIS_IN_TDATA[IDW-1:0];
                    cnt_next    = CW'(BEATS_PER_PACKET);
                    state_next  = S_DATA;
                end
            end
            S_DATA: begin
                if (in_hs) begin
                    cnt_next = cnt_reg - CW'(1);
                    if (last_beat) begin
                        state_next = S_FTR;
                    end
                end
            end
            S_FTR: begin
                if (in_hs) begin
                    pkt_count_next = pkt_count_reg + 32'd1;
                    if (AXIS_IN_TDATA[IDW-1:0] != req_id_reg) begin
                        err_count_next  = err_count_reg + 32'd1;
                        footer_err_next = 1'b1;
                    end
                    state_next = S_HDR;
                end
            end
            default: begin
                state_next = S_HDR;
            end
        endcase
    end

    // State, counters and status registers; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= S_HDR;
            cnt_reg        <= '0;
            req_id_reg     <= '0;
            pkt_count_reg  <= 32'd0;
            err_count_reg  <= 32'd0;
            footer_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            req_id_reg     <= req_id_next;
            pkt_count_reg  <= pkt_count_next;
            err_count_reg  <= err_count_next;
            footer_err_reg <= footer_err_next;
        end
    end

    axis_skid #(
        .W(SW)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (skid_in_data),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (AXIS_OUT_TVALID),
        .out_ready (AXIS_OUT_TREADY)
    );

endmodule

// File: tb/tb_pkt_framer.sv
// Randomized self-checking bench for pkt_framer with a packet-level reference model.
module tb_pkt_framer;
    import pkt_pkg::*;

    localparam int DW  = DEF_DW;
    localparam int IDW = DEF_IDW;
    localparam int BPP = DEF_BEATS;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [IDW-1:0] u;
        logic           l;
    } beat_t;

    logic           clk;
    logic           resetn;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  out_data;
    logic [IDW-1:0] out_user;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    pkt_count;
    logic [31:0]    err_count;
    logic           footer_err;

    logic           s_resetn;
    logic [DW-1:0]  s_in_data;
    logic           s_in_valid;
    logic           s_in_ready;
    logic [DW-1:0]  s_out_data;
    logic [IDW-1:0] s_out_user;
    logic           s_out_last;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [31:0]    s_pkt_count;
    logic [31:0]    s_err_count;
    logic           s_footer_err;

    pkt_framer #(.DW(DW), .IDW(IDW), .BEATS_PER_PACKET(BPP)) dut (
        .clk(clk), .resetn(resetn),
        .AXIS_IN_TDATA(in_data), .AXIS_IN_TVALID(in_valid), .AXIS_IN_TREADY(in_ready),
        .AXIS_OUT_TDATA(out_data), .AXIS_OUT_TUSER(out_user), .AXIS_OUT_TLAST(out_last),
        .AXIS_OUT_TVALID(out_valid), .AXIS_OUT_TREADY(out_ready),
        .pkt_count(pkt_count), .err_count(err_count), .footer_err(footer_err)
    );

    pkt_framer #(.DW(DW), .IDW(IDW), .BEATS_PER_PACKET(1)) dut_one (
        .clk(clk), .resetn(s_resetn),
        .AXIS_IN_TDATA(s_in_data), .AXIS_IN_TVALID(s_in_valid), .AXIS_IN_TREADY(s_in_ready),
        .AXIS_OUT_TDATA(s_out_data), .AXIS_OUT_TUSER(s_out_user), .AXIS_OUT_TLAST(s_out_last),
        .AXIS_OUT_TVALID(s_out_valid), .AXIS_OUT_TREADY(s_out_ready),
        .pkt_count(s_pkt_count), .err_count(s_err_count), .footer_err(s_footer_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus-side bookkeeping (owned by the main initial block).
    beat_t          exp_q[$];
    logic [DW-1:0]  pkt_dat [BPP];
    int             exp_pkt = 0;
    int             exp_err = 0;
    int             accepted = 0;
    int             stall_cnt = 0;
    int             ftr_ncyc = 0;
    int             rdy_mode = 0;
    bit             cur_is_data = 1'b0;

    // Monitor-side bookkeeping (owned by the monitor process).
    beat_t          obs_q[$];
    int             ncyc = 0;
    int             popped = 0;
    int             max_occ = 0;
    int             valid_viol = 0;
    int             ready_viol = 0;
    int             stab_viol = 0;
    int             ferr_cycles = 0;
    int             ferr_ncyc = -1;

    // Output-ready pattern generator: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: records accepted output beats and protocol observations, mid-cycle.
    initial begin
        bit    pend_pop;
        bit    prev_stall;
        beat_t prev_beat;
        beat_t cur;
        int    occ;
        pend_pop = 1'b0;
        prev_stall = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            cur.d = out_data;
            cur.u = out_user;
            cur.l = out_last;
            if (resetn !== 1'b1) begin
                popped = accepted;
                pend_pop = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (pend_pop) popped++;
                pend_pop = 1'b0;
                occ = accepted - popped;
                if (occ > max_occ) max_occ = occ;
                if (out_valid !== (occ != 0)) valid_viol++;
                if (in_valid === 1'b1) begin
                    if (cur_is_data) begin
                        if (in_ready !== (occ < 2)) ready_viol++;
                    end else if (in_ready !== 1'b1) begin
                        ready_viol++;
                    end
                end
                if (prev_stall && (out_valid !== 1'b1 || cur !== prev_beat)) stab_viol++;
                if (footer_err === 1'b1) begin
                    ferr_cycles++;
                    ferr_ncyc = ncyc;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    obs_q.push_back(cur);
                    pend_pop = 1'b1;
                end
                prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
                prev_beat = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference model: a packet yields its payload in order, tagged with the header ID,
    // TLAST on its final beat only.
    task automatic model_packet(input logic [IDW-1:0] hdr);
        beat_t b;
        for (int i = 0; i < BPP; i++) begin
            b.d = pkt_dat[i];
            b.u = hdr;
            b.l = (i == BPP - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic int stream_errs(input int base);
        int e;
        e = 0;
        if (obs_q.size() - base != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                if (obs_q[base + i] !== exp_q[i]) e++;
            end
        end
        return e;
    endfunction

    task automatic drive_beat(input logic [DW-1:0] d, input bit is_data);
        bit hs;
        bit ok;
        in_data = d;
        in_valid = 1'b1;
        cur_is_data = is_data;
        ok = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            hs = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                if (is_data) accepted++;
                break;
            end
            stall_cnt++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL in_handshake: beat not accepted within 200 cycles, required acceptance");
        end
    endtask

    task automatic send_packet(input logic [IDW-1:0] hdr, input logic [IDW-1:0] ftr,
                               input bit bubbles, input int n_data);
        logic [DW-1:0] w;
        for (int i = 0; i < BPP; i++) pkt_dat[i] = rand_word();
        model_packet(hdr);
        w = rand_word();
        w[IDW-1:0] = hdr;
        drive_beat(w, 1'b0);
        for (int i = 0; i < n_data; i++) begin
            if (bubbles) begin
                @(posedge clk);
                #1;
            end
            drive_beat(pkt_dat[i], 1'b1);
        end
        if (n_data == BPP) begin
            w = rand_word();
            w[IDW-1:0] = ftr;
            drive_beat(w, 1'b0);
            ftr_ncyc = ncyc;
            exp_pkt++;
            if (ftr != hdr) exp_err++;
        end
    endtask

    task automatic wait_drain(input int base);
        for (int c = 0; c < 1000; c++) begin
            if (obs_q.size() >= base + exp_q.size()) break;
            @(posedge clk);
            #1;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (pkt_count !== 32'd0 || err_count !== 32'd0 || footer_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters: got pkt=%0d err=%0d ferr=%b want 0/0/0", pkt_count, err_count, footer_err);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        int base, e, st0, nlast;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        exp_q.delete();
        base = obs_q.size();
        st0 = stall_cnt;
        send_packet(32'h11, 32'h11, 1'b0, BPP);
        send_packet(32'h12, 32'h12, 1'b0, BPP);
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL b2b_stream: %0d bad beats, got %0d beats want %0d", e, obs_q.size() - base, exp_q.size()); end
        nlast = 0;
        for (int i = base; i < obs_q.size(); i++) if (obs_q[i].l) nlast++;
        checks++;
        if (nlast !== 2) begin failures++; $display("FAIL b2b_tlast_count: got %0d want 2", nlast); end
        checks++;
        if (stall_cnt - st0 !== 0) begin failures++; $display("FAIL b2b_throughput: got %0d input stalls want 0", stall_cnt - st0); end
        checks++;
        if (pkt_count !== 32'(exp_pkt) || err_count !== 32'(exp_err)) begin
            failures++;
            $display("FAIL b2b_counters: got pkt=%0d err=%0d want %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
        end
        checks++;
        if (ferr_cycles !== 0) begin failures++; $display("FAIL b2b_footer_err: got %0d pulse cycles want 0", ferr_cycles); end
        $display("test_back_to_back done: %0d beats", obs_q.size() - base);
    endtask

    task automatic test_footer_mismatch();
        int base, e, f0;
        rdy_mode = 0;
        exp_q.delete();
        base = obs_q.size();
        f0 = ferr_cycles;
        send_packet(32'h55, 32'h56, 1'b0, BPP);
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL mismatch_stream: %0d bad beats", e); end
        checks++;
        if (ferr_cycles - f0 !== 1) begin failures++; $display("FAIL mismatch_pulse_width: got %0d cycles want 1", ferr_cycles - f0); end
        checks++;
        if (ferr_ncyc !== ftr_ncyc + 1) begin failures++; $display("FAIL mismatch_pulse_time: got cycle %0d want %0d", ferr_ncyc, ftr_ncyc + 1); end
        checks++;
        if (pkt_count !== 32'(exp_pkt) || err_count !== 32'(exp_err)) begin
            failures++;
            $display("FAIL mismatch_counters: got pkt=%0d err=%0d want %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
        end
        $display("test_footer_mismatch done: pkt=%0d err=%0d", pkt_count, err_count);
    endtask

    task automatic test_backpressure();
        int base, e, sv0, rv0, vv0;
        rdy_mode = 1;
        exp_q.delete();
        base = obs_q.size();
        sv0 = stab_viol; rv0 = ready_viol; vv0 = valid_viol;
        max_occ = 0;
        send_packet(IDW'($urandom), 32'h0, 1'b0, BPP);
        exp_q.delete();
        exp_err = (exp_q.size() == 0) ? exp_err : exp_err;
        rdy_mode = 0;
        wait_drain(obs_q.size());
        rdy_mode = 1;
        exp_q.delete();
        base = obs_q.size();
        send_packet(32'h2024, 32'h2024, 1'b0, BPP);
        send_packet(32'h2025, 32'h2025, 1'b0, BPP);
        rdy_mode = 0;
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL bp_stream: %0d bad beats, got %0d want %0d", e, obs_q.size() - base, exp_q.size()); end
        checks++;
        if (stab_viol - sv0 !== 0) begin failures++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_viol - sv0); end
        checks++;
        if (ready_viol - rv0 !== 0) begin failures++; $display("FAIL bp_in_ready: got %0d wrong ready cycles want 0", ready_viol - rv0); end
        checks++;
        if (valid_viol - vv0 !== 0) begin failures++; $display("FAIL bp_out_valid: got %0d wrong valid cycles want 0", valid_viol - vv0); end
        checks++;
        if (max_occ !== 2) begin failures++; $display("FAIL bp_fill: got max occupancy %0d want 2", max_occ); end
        checks++;
        if (pkt_count !== 32'(exp_pkt) || err_count !== 32'(exp_err)) begin
            failures++;
            $display("FAIL bp_counters: got pkt=%0d err=%0d want %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
        end
        $display("test_backpressure done: %0d beats", obs_q.size() - base);
    endtask

    task automatic test_bubbles();
        int base, e;
        rdy_mode = 0;
        exp_q.delete();
        base = obs_q.size();
        send_packet(32'hB0B0, 32'hB0B0, 1'b1, BPP);
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL bubbles_stream: %0d bad beats", e); end
        checks++;
        if (obs_q.size() >= base + BPP && obs_q[base + BPP - 1].l !== 1'b1) begin
            failures++;
            $display("FAIL bubbles_tlast: got %b on beat %0d want 1", obs_q[base + BPP - 1].l, BPP - 1);
        end
        $display("test_bubbles done");
    endtask

    task automatic test_random_mix();
        int base, e, f0, err0, rv0, sv0, vv0;
        logic [IDW-1:0] id;
        logic [IDW-1:0] fid;
        rdy_mode = 2;
        exp_q.delete();
        base = obs_q.size();
        f0 = ferr_cycles; err0 = exp_err;
        rv0 = ready_viol; sv0 = stab_viol; vv0 = valid_viol;
        for (int p = 0; p < 4; p++) begin
            id = IDW'($urandom);
            fid = ($urandom_range(0, 2) == 0) ? (id ^ IDW'(1 << $urandom_range(0, IDW - 1))) : id;
            send_packet(id, fid, 1'($urandom_range(0, 1)), BPP);
        end
        rdy_mode = 0;
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL mix_stream: %0d bad beats", e); end
        checks++;
        if (ferr_cycles - f0 !== exp_err - err0) begin failures++; $display("FAIL mix_pulses: got %0d want %0d", ferr_cycles - f0, exp_err - err0); end
        checks++;
        if (ready_viol - rv0 + stab_viol - sv0 + valid_viol - vv0 !== 0) begin
            failures++;
            $display("FAIL mix_protocol: got %0d violations want 0", ready_viol - rv0 + stab_viol - sv0 + valid_viol - vv0);
        end
        checks++;
        if (pkt_count !== 32'(exp_pkt) || err_count !== 32'(exp_err)) begin
            failures++;
            $display("FAIL mix_counters: got pkt=%0d err=%0d want %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
        end
        $display("test_random_mix done: pkt=%0d err=%0d", pkt_count, err_count);
    endtask

    task automatic test_reset_mid();
        int base, e;
        rdy_mode = 0;
        exp_q.delete();
        send_packet(32'h33, 32'h33, 1'b0, 10);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++;
        if (pkt_count !== 32'd0 || err_count !== 32'd0 || footer_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_counters: got pkt=%0d err=%0d ferr=%b want 0/0/0", pkt_count, err_count, footer_err);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        exp_q.delete();
        base = obs_q.size();
        send_packet(32'h77, 32'h77, 1'b0, BPP);
        wait_drain(base);
        e = stream_errs(base);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL midrst_stream: %0d bad beats, got %0d want %0d", e, obs_q.size() - base, exp_q.size()); end
        checks++;
        if (pkt_count !== 32'd1 || err_count !== 32'd0) begin
            failures++;
            $display("FAIL midrst_after: got pkt=%0d err=%0d want 1/0", pkt_count, err_count);
        end
        $display("test_reset_mid done");
    endtask

    task automatic s_drive(input logic [DW-1:0] d, output bit ok);
        bit hs;
        s_in_data = d;
        s_in_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            hs = (s_in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        bit ok0, ok1, ok2;
        s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_resetn = 1'b1;
        w = rand_word();
        w[IDW-1:0] = 32'hA;
        s_drive(w, ok0);
        d = rand_word();
        s_drive(d, ok1);
        @(negedge clk);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_last !== 1'b1 || s_out_user !== 32'hA || s_out_data !== d) begin
            failures++;
            $display("FAIL single_beat: got valid=%b last=%b user=%h data_ok=%b want 1/1/0000000a/1",
                     s_out_valid, s_out_last, s_out_user, s_out_data === d);
        end
        w = rand_word();
        w[IDW-1:0] = 32'hA;
        s_drive(w, ok2);
        @(negedge clk);
        checks++;
        if (!(ok0 && ok1 && ok2) || s_out_valid !== 1'b0 || s_pkt_count !== 32'd1 || s_err_count !== 32'd0) begin
            failures++;
            $display("FAIL single_after: got hs=%b%b%b valid=%b pkt=%0d err=%0d want 111/0/1/0",
                     ok0, ok1, ok2, s_out_valid, s_pkt_count, s_err_count);
        end
        $display("test_single_beat done");
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        s_resetn = 1'b0;
        s_in_valid = 1'b0;
        s_in_data = '0;
        s_out_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_footer_mismatch();
        test_backpressure();
        test_bubbles();
        test_random_mix();
        test_reset_mid();
        test_single_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_framer.md
Name: pkt_framer

Overview:
- Sits directly downstream of the request manager's 512-bit TX stream.
- Input framing per packet: 1 header beat (request ID), BEATS_PER_PACKET data beats, 1 footer beat (request ID).
- Strips header and footer, emits data beats with request ID on TUSER and TLAST on the final beat, checks footer ID against header ID.
- Maintains packet/error counters for the status register block.

Parameters:
- DW, 512, data width of input and output streams
- IDW, 32, request-ID width; ID occupies in TDATA[IDW-1:0] of header/footer beats
- BEATS_PER_PACKET, 32, data beats between header and footer (>=1)

Ports:
- clk  input  1  clock; everything synchronous to rising edge
- resetn  input  1  synchronous reset, active-low
- AXIS_IN_TDATA  input  DW  framed stream from request manager
- AXIS_IN_TVALID  input  1  input valid
- AXIS_IN_TREADY  output  1  input ready
- AXIS_OUT_TDATA  output  DW  payload beat
- AXIS_OUT_TUSER  output  IDW  request ID of the packet this beat belongs to
- AXIS_OUT_TLAST  output  1  high on final payload beat of a packet
- AXIS_OUT_TVALID  output  1  output valid
- AXIS_OUT_TREADY  input  1  output ready
- pkt_count  output  32  footers consumed since reset
- err_count  output  32  footers whose ID mismatched the header
- footer_err  output  1  one-cycle pulse on a mismatching footer

Behaviour:
- Reset (resetn==0 at clk edge): FSM->S_HDR, beat counter 0, skid buffer emptied, AXIS_OUT_TVALID=0, pkt_count=0, err_count=0, footer_err=0. AXIS_IN_TREADY=0 while resetn==0. Reset mid-packet drops the partial packet; the next accepted beat is treated as a header.
- Handshake: a beat transfers when TVALID & TREADY at a clk edge. Output TVALID/TDATA/TUSER/TLAST hold stable until accepted.
- Input TREADY:
  - 1 in S_HDR and S_FTR (beat is consumed internally).
  - In S_DATA, equals the skid buffer's "not full" flag.
- FSM:
  - S_HDR: on handshake, latch req_id <= TDATA[IDW-1:0]; beat counter <= BEATS_PER_PACKET; -> S_DATA.
  - S_DATA: on handshake, push {TDATA, req_id, last=(counter==1)} into skid; counter decrements; when counter==1 at handshake -> S_FTR.
  - S_FTR: on handshake, pkt_count++. If TDATA[IDW-1:0] != req_id: err_count++, footer_err=1 for the next cycle. Then -> S_HDR.
- Counters wrap modulo 2^32. footer_err is registered, so it is high exactly one cycle after the footer handshake.
- Output path: 2-entry skid buffer, registered outputs.
  - Latency: input data handshake to AXIS_OUT_TVALID is 1 cycle.
  - Sustains 1 beat/cycle with TREADY held high.
  - Full when 2 entries held. Simultaneous push and pop while full is not possible, because TREADY is low when full.
  - Push and pop in the same cycle keep occupancy unchanged.
- Header/footer beats never appear on the output. A header may be accepted the cycle after a footer, so the per-packet overhead is 2 input cycles.
- Output stalls back-pressure only S_DATA. Header and footer are still consumed while the skid buffer is full.

Decomposition:
- Shared package pkt_pkg: DW, IDW, BEATS_PER_PACKET defaults; FSM state encoding (S_HDR=0, S_DATA=1, S_FTR=2).
- Sub-module axis_skid: 2-entry AXIS register slice, width DW+IDW+1, ports for valid/ready in and out, synchronous active-low reset. Reusable elsewhere in the design.

Test Plan:
- Back-to-back packets: header 0x11, 32 beats D0..D31, footer 0x11, then header 0x12, 32 beats, footer 0x12; OUT_TREADY=1 -> 64 output beats in order; TUSER=0x11 for the first 32 and 0x12 for the rest; TLAST on beats 31 and 63 only; pkt_count=2, err_count=0, no footer_err.
- Footer mismatch: header 0x55, 32 beats, footer 0x56 -> all 32 beats out with TUSER=0x55; footer_err pulses exactly 1 cycle; err_count=1, pkt_count=1.
- Back-pressure: OUT_TREADY toggled 1-0-1-0 during the data phase -> no beat lost or duplicated; TDATA/TUSER/TLAST stable while TVALID=1 and TREADY=0; IN_TREADY low whenever the skid buffer holds 2 entries.
- Input bubbles: IN_TVALID low on alternate cycles -> output order correct; TLAST on the 32nd payload beat.
- Reset mid-packet: assert resetn=0 after 10 data beats, release, then send a full packet with ID 0x77 -> only the 32 beats of 0x77 appear; TVALID=0 during reset; counters restart at 0, then pkt_count=1.
- Parameter variant BEATS_PER_PACKET=1: header 0xA, one beat, footer 0xA -> a single output beat with TLAST=1 and TUSER=0xA.
